reversi_move_engine: RTL and testbench



---
 rtl/reversi_move_engine_if.sv | 37 +++
 rtl/reversi_move_engine.sv | 261 ++++++++++++++++++++++++++
 tb/tb_reversi_move_engine.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/reversi_move_engine_if.sv
// Request/response and board bus between the game FSM, the VGA draw logic and reversi_move_engine.
// REVERSI_AUTO_HINT_EN adds the no_moves status line.
interface reversi_move_engine_if #(
  parameter int N = 8
);
  localparam int CW = $clog2(N);

  logic [CW-1:0]    x;
  logic [CW-1:0]    y;
  logic             player;
  logic             mode;
  logic             go;
  logic             busy;
  logic             done;
  logic             legal;
  logic [CW+2:0]    flip_count;
  logic [3*N*N-1:0] board;
`ifdef REVERSI_AUTO_HINT_EN
  logic             no_moves;
`endif

  modport master (
    output x, y, player, mode, go,
    input  busy, done, legal, flip_count, board
`ifdef REVERSI_AUTO_HINT_EN
    , input no_moves
`endif
  );

  modport slave (
    input  x, y, player, mode, go,
    output busy, done, legal, flip_count, board
`ifdef REVERSI_AUTO_HINT_EN
    , output no_moves
`endif
  );
endinterface

// File: rtl/reversi_move_engine.sv
// N x N reversi board engine: one place-with-flips or hint-sweep request per go.
// Build macro REVERSI_AUTO_HINT_EN chains an opponent hint sweep after every legal place.
module reversi_move_engine #(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  reversi_move_engine_if.slave bus
);
  localparam int CW = $clog2(N);
  localparam int BW = 3 * N * N;
  localparam int IW = $clog2(BW);

  typedef enum logic [2:0] {IDLE, CHECK, SCAN, FLIP, PLACE, HSCAN, HNEXT, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic          player_q, player_d;
  logic [2:0]    dir_q, dir_d;
  logic [CW:0]   step_q, step_d;
  logic [CW+2:0] flip_count_q, flip_count_d;
  logic          legal_q, legal_d;
  logic          any_valid_q, any_valid_d;
  logic          marked_q, marked_d;
  logic [BW-1:0] board_q, board_d;
`ifdef REVERSI_AUTO_HINT_EN
  logic          chain_q, chain_d;
  logic          no_moves_q, no_moves_d;
`endif

  int            wx, wy;
  logic          on_board, w_empty, w_own, t_in_range, last_cell, adv, start_hint;
  logic [IW-1:0] widx, tidx;
  logic [2:0]    wcell, tcell, own_code;

  function automatic logic [BW-1:0] reset_board();
    logic [BW-1:0] b;
    b = '0;
    b[3*((N/2-1)*N + N/2-1) +: 3] = 3'b110;
    b[3*((N/2-1)*N + N/2)   +: 3] = 3'b111;
    b[3*((N/2)*N   + N/2-1) +: 3] = 3'b111;
    b[3*((N/2)*N   + N/2)   +: 3] = 3'b110;
    return b;
  endfunction

  // d = 0..7 : N, NE, E, SE, S, SW, W, NW (north is row y-1)
  function automatic int dir_dx(logic [2:0] d);
    case (d)
      3'd1, 3'd2, 3'd3: return 1;
      3'd5, 3'd6, 3'd7: return -1;
      default:          return 0;
    endcase
  endfunction

  function automatic int dir_dy(logic [2:0] d);
    case (d)
      3'd7, 3'd0, 3'd1: return -1;
      3'd3, 3'd4, 3'd5: return 1;
      default:          return 0;
    endcase
  endfunction

  // Walk cell at target + step*(dx,dy), plus the target cell itself (also the hint cursor).
  always_comb begin
    wx         = int'(x_q) + int'(step_q) * dir_dx(dir_q);
    wy         = int'(y_q) + int'(step_q) * dir_dy(dir_q);
    on_board   = (wx >= 0) && (wx < N) && (wy >= 0) && (wy < N);
    widx       = on_board ? IW'(3 * (wy * N + wx)) : '0;
    wcell      = on_board ? board_q[widx +: 3] : 3'b000;
    w_empty    = (wcell[2:1] != 2'b11);
    w_own      = !w_empty && (wcell[0] == player_q);
    t_in_range = (int'(x_q) < N) && (int'(y_q) < N);
    tidx       = t_in_range ? IW'(3 * (int'(y_q) * N + int'(x_q))) : '0;
    tcell      = t_in_range ? board_q[tidx +: 3] : 3'b000;
    own_code   = {2'b11, player_q};
    last_cell  = (int'(x_q) == N - 1) && (int'(y_q) == N - 1);
  end

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    player_d     = player_q;
    dir_d        = dir_q;
    step_d       = step_q;
    flip_count_d = flip_count_q;
    legal_d      = legal_q;
    any_valid_d  = any_valid_q;
    marked_d     = marked_q;
    board_d      = board_q;
    adv          = 1'b0;
    start_hint   = 1'b0;
`ifdef REVERSI_AUTO_HINT_EN
    chain_d      = chain_q;
    no_moves_d   = no_moves_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.go) begin
          x_d      = bus.x;
          y_d      = bus.y;
          player_d = bus.player;
          legal_d  = 1'b0;
`ifdef REVERSI_AUTO_HINT_EN
          chain_d    = 1'b0;
          no_moves_d = 1'b0;
`endif
          if (bus.mode) start_hint = 1'b1;
          else          state_d    = CHECK;
        end
      end
      CHECK: begin
        flip_count_d = '0;
        if (!t_in_range || tcell[2:1] == 2'b11) begin
          legal_d = 1'b0;
          state_d = DONE;
        end else begin
          dir_d   = '0;
          step_d  = (CW+1)'(1);
          state_d = SCAN;
        end
      end
      SCAN, HSCAN: begin
        if (w_empty || (w_own && step_q == (CW+1)'(1))) begin
          adv = 1'b1;
        end else if (!w_own) begin
          step_d = step_q + (CW+1)'(1);
        end else if (state_q == SCAN) begin
          step_d  = (CW+1)'(1);
          state_d = FLIP;
        end else begin
          any_valid_d = 1'b1;
          adv         = 1'b1;
        end
      end
      FLIP: begin
        if (w_own || !on_board) begin
          adv = 1'b1;
        end else begin
          board_d[widx +: 3] = own_code;
          flip_count_d       = flip_count_q + (CW+3)'(1);
          step_d             = step_q + (CW+1)'(1);
        end
      end
      PLACE: begin
        if (flip_count_q != '0) begin
          for (int unsigned i = 0; i < N * N; i++) begin
            if (board_q[IW'(3 * i) +: 3] == 3'b100) board_d[IW'(3 * i) +: 3] = 3'b000;
          end
          board_d[tidx +: 3] = own_code;
          legal_d            = 1'b1;
`ifdef REVERSI_AUTO_HINT_EN
          chain_d    = 1'b1;
          player_d   = !player_q;
          start_hint = 1'b1;
`else
          state_d = DONE;
`endif
        end else begin
          legal_d = 1'b0;
          state_d = DONE;
        end
      end
      HNEXT: begin
        if (tcell[2:1] != 2'b11) begin
          board_d[tidx +: 3] = any_valid_q ? 3'b100 : 3'b000;
          if (any_valid_q) marked_d = 1'b1;
        end
        if (last_cell) begin
`ifdef REVERSI_AUTO_HINT_EN
          if (chain_q) no_moves_d = !marked_d;
          else         legal_d    = marked_d;
`else
          legal_d = marked_d;
`endif
          state_d = DONE;
        end else begin
          if (int'(x_q) == N - 1) begin
            x_d = '0;
            y_d = y_q + CW'(1);
          end else begin
            x_d = x_q + CW'(1);
          end
          dir_d       = '0;
          step_d      = (CW+1)'(1);
          any_valid_d = 1'b0;
          state_d     = HSCAN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Direction exhausted: FLIP resumes in SCAN, hint walks stay in HSCAN.
    if (adv) begin
      step_d = (CW+1)'(1);
      if (dir_q == 3'd7) begin
        state_d = (state_q == HSCAN) ? HNEXT : PLACE;
      end else begin
        dir_d   = dir_q + 3'd1;
        state_d = (state_q == HSCAN) ? HSCAN : SCAN;
      end
    end

    if (start_hint) begin
      x_d         = '0;
      y_d         = '0;
      dir_d       = '0;
      step_d      = (CW+1)'(1);
      any_valid_d = 1'b0;
      marked_d    = 1'b0;
      state_d     = HSCAN;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      player_q     <= 1'b0;
      dir_q        <= '0;
      step_q       <= '0;
      flip_count_q <= '0;
      legal_q      <= 1'b0;
      any_valid_q  <= 1'b0;
      marked_q     <= 1'b0;
      board_q      <= reset_board();
`ifdef REVERSI_AUTO_HINT_EN
      chain_q      <= 1'b0;
      no_moves_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      player_q     <= player_d;
      dir_q        <= dir_d;
      step_q       <= step_d;
      flip_count_q <= flip_count_d;
      legal_q      <= legal_d;
      any_valid_q  <= any_valid_d;
      marked_q     <= marked_d;
      board_q      <= board_d;
`ifdef REVERSI_AUTO_HINT_EN
      chain_q      <= chain_d;
      no_moves_q   <= no_moves_d;
`endif
    end
  end

  assign bus.busy       = (state_q != IDLE) && (state_q != DONE);
  assign bus.done       = (state_q == DONE);
  assign bus.legal      = legal_q;
  assign bus.flip_count = flip_count_q;
  assign bus.board      = board_q;
`ifdef REVERSI_AUTO_HINT_EN
  assign bus.no_moves   = no_moves_q;
`endif
endmodule

// File: tb/tb_reversi_move_engine.sv
// Directed, table-driven bench for reversi_move_engine (N=8, default build).
module tb_reversi_move_engine;
  localparam int N         = 8;
  localparam int CW        = $clog2(N);
  localparam int BW        = 3 * N * N;
  localparam int PLACE_MAX = 2 + 16 * N;
  localparam int HINT_MAX  = N * N * (8 * N + 1) + 2;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  reversi_move_engine_if #(.N(N)) bus();
  reversi_move_engine #(.N(N)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  int checks   = 0;
  int failures = 0;
  logic [BW-1:0] exp_board, rst_board;

  typedef struct {
    bit rst; int x; int y; bit player; bit mode; bit legal; int flip; int nedit;
    logic [5:0][3:0] ex; logic [5:0][3:0] ey; logic [5:0][2:0] ec;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string nm, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic add_vec(input bit rst, input int x, input int y, input bit p, input bit m,
                         input bit lg, input int fc);
    vec_t v;
    v.rst = rst; v.x = x; v.y = y; v.player = p; v.mode = m; v.legal = lg; v.flip = fc;
    v.nedit = 0; v.ex = '0; v.ey = '0; v.ec = '0;
    vecs.push_back(v);
  endtask

  task automatic add_edit(input int x, input int y, input logic [2:0] c);
    vec_t v;
    v = vecs[vecs.size() - 1];
    v.ex[v.nedit] = 4'(x);
    v.ey[v.nedit] = 4'(y);
    v.ec[v.nedit] = c;
    v.nedit++;
    vecs[vecs.size() - 1] = v;
  endtask

  task automatic set_cell(input int x, input int y, input logic [2:0] c);
    exp_board[3 * (y * N + x) +: 3] = c;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic start_req(input int x, input int y, input bit p, input bit m);
    @(negedge clk);
    bus.x = CW'(x); bus.y = CW'(y); bus.player = p; bus.mode = m; bus.go = 1'b1;
    @(negedge clk);
    bus.go = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, ndone;
    bus.go = 1'b0; bus.x = '0; bus.y = '0; bus.player = 1'b0; bus.mode = 1'b0;

    exp_board = '0;
    set_cell(3, 3, 3'b110); set_cell(4, 3, 3'b111);
    set_cell(3, 4, 3'b111); set_cell(4, 4, 3'b110);
    rst_board = exp_board;

    //      rst x  y  p  m  legal flip
    add_vec(1,  3, 2, 1, 0, 1, 1); add_edit(3, 2, 3'b111); add_edit(3, 3, 3'b111);
    add_vec(0,  2, 2, 0, 0, 1, 1); add_edit(2, 2, 3'b110); add_edit(3, 3, 3'b110);
    add_vec(0,  2, 3, 1, 0, 1, 1); add_edit(2, 3, 3'b111); add_edit(3, 3, 3'b111);
    add_vec(0,  2, 4, 0, 0, 1, 2); add_edit(2, 4, 3'b110); add_edit(2, 3, 3'b110);
                                   add_edit(3, 4, 3'b110);
    add_vec(0,  2, 4, 0, 0, 0, 0);
    add_vec(1,  0, 0, 1, 0, 0, 0);
    add_vec(1,  0, 0, 1, 1, 1, 0); add_edit(3, 2, 3'b100); add_edit(2, 3, 3'b100);
                                   add_edit(5, 4, 3'b100); add_edit(4, 5, 3'b100);
    add_vec(0,  2, 3, 1, 0, 1, 1); add_edit(2, 3, 3'b111); add_edit(3, 3, 3'b111);
                                   add_edit(3, 2, 3'b000); add_edit(5, 4, 3'b000);
                                   add_edit(4, 5, 3'b000);
    add_vec(0,  0, 0, 0, 1, 1, 1); add_edit(2, 2, 3'b100); add_edit(4, 2, 3'b100);
                                   add_edit(2, 4, 3'b100);
    add_vec(0,  0, 0, 0, 1, 1, 1);
    add_vec(0,  4, 2, 0, 0, 1, 1); add_edit(4, 2, 3'b110); add_edit(4, 3, 3'b110);
                                   add_edit(2, 2, 3'b000); add_edit(2, 4, 3'b000);

    do_reset();
    chk("reset_board", bus.board, rst_board);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_legal", bus.legal, 0);
    chk("reset_flip", bus.flip_count, 0);

    foreach (vecs[i]) begin
      if (vecs[i].rst) begin
        do_reset();
        exp_board = rst_board;
      end
      start_req(vecs[i].x, vecs[i].y, vecs[i].player, vecs[i].mode);
      chk($sformatf("v%0d_busy_rise", i), bus.busy, 1);
      wait_done(vecs[i].mode ? HINT_MAX : PLACE_MAX, cyc);
      for (int k = 0; k < vecs[i].nedit; k++)
        set_cell(int'(vecs[i].ex[k]), int'(vecs[i].ey[k]), vecs[i].ec[k]);
      chk($sformatf("v%0d_done", i), bus.done, 1);
      chk($sformatf("v%0d_busy_at_done", i), bus.busy, 0);
      chk($sformatf("v%0d_legal", i), bus.legal, vecs[i].legal);
      chk($sformatf("v%0d_flip", i), bus.flip_count, vecs[i].flip);
      chk($sformatf("v%0d_board", i), bus.board, exp_board);
      @(negedge clk);
      chk($sformatf("v%0d_done_single", i), bus.done, 0);
      chk($sformatf("v%0d_legal_hold", i), bus.legal, vecs[i].legal);
    end

    // go while busy must be ignored: a different target is offered mid-request.
    do_reset();
    exp_board = rst_board;
    start_req(3, 2, 1, 0);
    @(negedge clk);
    bus.x = CW'(0); bus.y = CW'(0); bus.player = 1'b0; bus.go = 1'b1;
    repeat (2) @(negedge clk);
    bus.go = 1'b0;
    ndone = 0;
    for (int c = 0; c < PLACE_MAX; c++) begin
      if (bus.done === 1'b1) ndone++;
      @(negedge clk);
    end
    set_cell(3, 2, 3'b111); set_cell(3, 3, 3'b111);
    chk("busy_go_done_count", ndone, 1);
    chk("busy_go_legal", bus.legal, 1);
    chk("busy_go_flip", bus.flip_count, 1);
    chk("busy_go_board", bus.board, exp_board);
    chk("busy_go_idle", bus.busy, 0);

    // Reset while the (3,3) flip is being written aborts cleanly.
    do_reset();
    start_req(3, 2, 1, 0);
    repeat (7) @(negedge clk);
    chk("abort_busy_before", bus.busy, 1);
    resetn = 1'b0;
    @(negedge clk);
    chk("abort_board", bus.board, rst_board);
    chk("abort_busy", bus.busy, 0);
    resetn = 1'b1;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.done === 1'b1) ndone++;
      @(negedge clk);
    end
    chk("abort_no_done", ndone, 0);
    chk("abort_board_after", bus.board, rst_board);
    chk("abort_legal", bus.legal, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
